// File: rtl/tmr_pkg.sv
// ---------------------------------------------------------------------------
// tmr_pkg
// Shared constants for the TMR error monitor slice.
//   REP0..REP2   : replica indices used to address per-replica arrays
//   DEF_W        : default replica data width
//   DEF_CNT_W    : default per-replica upset counter width
//   DEF_STUCK_N  : default number of consecutive mismatch cycles that mark a
//                  replica as stuck
//   multi_hot3() : true when two or more bits of a 3-bit vector are set
// ---------------------------------------------------------------------------
package tmr_pkg;

  localparam int REP0 = 0;
  localparam int REP1 = 1;
  localparam int REP2 = 2;

  localparam int DEF_W       = 8;
  localparam int DEF_CNT_W   = 8;
  localparam int DEF_STUCK_N = 4;

  function automatic logic multi_hot3(input logic [2:0] v);
    return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
  endfunction

endpackage

// File: rtl/tmr_sat_cnt.sv
// ---------------------------------------------------------------------------
// tmr_sat_cnt
// Up-counter that stops at MAX, with a synchronous load that takes
// priority over counting.
// Ports:
//   clk      : input           clock, rising edge
//   rst_n    : input           asynchronous active-low reset (count -> 0)
//   load     : input           load load_val this cycle
//   load_val : input  [W-1:0]  value loaded when load = 1
//   inc      : input           increment this cycle (ignored at MAX)
//   cnt      : output [W-1:0]  current count
// ---------------------------------------------------------------------------
module tmr_sat_cnt #(
  parameter int           W   = 8,
  parameter logic [W-1:0] MAX = '1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (inc && (cnt != MAX)) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/voter3.sv
// ---------------------------------------------------------------------------
// voter3
// Bitwise two-out-of-three majority voter.
// Ports:
//   a, b, c : input  [W-1:0]  replica values
//   y       : output [W-1:0]  bitwise majority of a, b, c
// ---------------------------------------------------------------------------
module voter3 #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] c,
  output logic [W-1:0] y
);

  assign y = (a & b) | (a & c) | (b & c);

endmodule

// File: rtl/tmr_err_mon.sv
// ---------------------------------------------------------------------------
// tmr_err_mon
// Watches the three raw replicas of a triplicated register, votes them, and
// keeps per-replica error statistics plus sticky fault flags and an
// interrupt.
//
// Optional feature: define TMR_STUCK_DET_EN to build the per-replica run
// counters and stuck flags. Without it, stuck reads 3'b000 and irq follows
// dbl_fault only.
//
// Ports:
//   clk        : input                clock, rising edge
//   rst_n      : input                asynchronous active-low reset
//   r0, r1, r2 : input  [W-1:0]       raw replica values
//   clr        : input                synchronous clear of counters/sticky flags
//   mis        : output [2:0]         registered per-replica mismatch flags
//   cnt0..cnt2 : output [CNT_W-1:0]   saturating per-replica upset counts
//   dbl_fault  : output               sticky: two or more replicas upset at once
//   stuck      : output [2:0]         sticky per-replica stuck flags
//   irq        : output               registered dbl_fault | (|stuck)
// ---------------------------------------------------------------------------
module tmr_err_mon
  import tmr_pkg::*;
#(
  parameter int W       = DEF_W,
  parameter int CNT_W   = DEF_CNT_W,
  parameter int STUCK_N = DEF_STUCK_N
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [W-1:0]     r0,
  input  logic [W-1:0]     r1,
  input  logic [W-1:0]     r2,
  input  logic             clr,
  output logic [2:0]       mis,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1,
  output logic [CNT_W-1:0] cnt2,
  output logic             dbl_fault,
  output logic [2:0]       stuck,
  output logic             irq
);

  logic [W-1:0]     rep [3];
  logic [W-1:0]     voted;
  logic [2:0]       mismatch;
  logic [CNT_W-1:0] cnt_q [3];
  logic             dbl_set;

  assign rep[REP0] = r0;
  assign rep[REP1] = r1;
  assign rep[REP2] = r2;

  voter3 #(.W(W)) u_voter (
    .a (r0),
    .b (r1),
    .c (r2),
    .y (voted)
  );

  // A replica is in error whenever any of its bits disagrees with the vote.
  always_comb begin
    mismatch = 3'b000;
    for (int i = 0; i < 3; i++) begin
      mismatch[i] = (rep[i] != voted);
    end
  end

  // Different replicas can each lose a different bit in the same cycle;
  // the vote still masks it, but it means the margin is gone.
  assign dbl_set = multi_hot3(mismatch);

  // Upset counters: clr reloads with this cycle's mismatch so a coincident
  // upset is never lost.
  for (genvar i = 0; i < 3; i++) begin : g_upset
    tmr_sat_cnt #(.W(CNT_W)) u_upset_cnt (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (clr),
      .load_val (CNT_W'(mismatch[i])),
      .inc      (mismatch[i]),
      .cnt      (cnt_q[i])
    );
  end

  assign cnt0 = cnt_q[REP0];
  assign cnt1 = cnt_q[REP1];
  assign cnt2 = cnt_q[REP2];

`ifdef TMR_STUCK_DET_EN
  localparam int               RUN_W   = $clog2(STUCK_N + 1);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(STUCK_N);

  logic [RUN_W-1:0] run_q [3];
  logic [2:0]       stuck_set;
  logic [2:0]       stuck_q;

  // Run counters track consecutive mismatch cycles. A clean cycle reloads
  // zero, and clr reloads 1 or 0 just like the upset counters.
  for (genvar i = 0; i < 3; i++) begin : g_run
    tmr_sat_cnt #(.W(RUN_W), .MAX(RUN_MAX)) u_run_cnt (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (clr | ~mismatch[i]),
      .load_val (RUN_W'(mismatch[i])),
      .inc      (mismatch[i]),
      .cnt      (run_q[i])
    );
  end

  always_comb begin
    stuck_set = 3'b000;
    for (int i = 0; i < 3; i++) begin
      stuck_set[i] = (run_q[i] == RUN_MAX);
    end
  end

  // Sticky stuck flags; during clr each bit takes its own set condition so
  // a replica that is still stuck stays flagged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stuck_q <= 3'b000;
    end else if (clr) begin
      stuck_q <= stuck_set;
    end else begin
      stuck_q <= stuck_q | stuck_set;
    end
  end

  assign stuck = stuck_q;
`else
  assign stuck = 3'b000;
`endif

  // Registered mismatch view, sticky double-fault flag and the interrupt.
  // irq samples the flag registers, so it trails them by one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mis       <= 3'b000;
      dbl_fault <= 1'b0;
      irq       <= 1'b0;
    end else begin
      mis <= mismatch;
      if (clr) begin
        dbl_fault <= dbl_set;
      end else if (dbl_set) begin
        dbl_fault <= 1'b1;
      end
      irq <= dbl_fault | (|stuck);
    end
  end

endmodule

// File: tb/tb_tmr_err_mon.sv
// ---------------------------------------------------------------------------
// tb_tmr_err_mon
// Directed self-checking bench for tmr_err_mon with default parameters
// (W = 8, CNT_W = 8, STUCK_N = 4). Expectations for the stuck feature follow
// whether TMR_STUCK_DET_EN is defined for the build.
// ---------------------------------------------------------------------------
module tb_tmr_err_mon;

`ifdef TMR_STUCK_DET_EN
  localparam bit STK = 1'b1;
`else
  localparam bit STK = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic [7:0] r0, r1, r2;
  logic       clr;
  logic [2:0] mis;
  logic [7:0] cnt0, cnt1, cnt2;
  logic       dbl_fault;
  logic [2:0] stuck;
  logic       irq;

  int vectors;
  int miscompares;

  tmr_err_mon dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .r0        (r0),
    .r1        (r1),
    .r2        (r2),
    .clr       (clr),
    .mis       (mis),
    .cnt0      (cnt0),
    .cnt1      (cnt1),
    .cnt2      (cnt2),
    .dbl_fault (dbl_fault),
    .stuck     (stuck),
    .irq       (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle 1 time unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_reps(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    r0 = a;
    r1 = b;
    r2 = c;
  endtask

  // Return to a clean state: one idle cycle so run counters drain, one clr
  // cycle, then one more so irq follows the cleared flags.
  task automatic clean_up();
    set_reps(8'hA5, 8'hA5, 8'hA5);
    clr = 1'b0;
    tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clr   = 1'b0;
    set_reps(8'hA5, 8'hA5, 8'hA5);
    tick();
    tick();
    vectors++;
    if ({mis, cnt0, cnt1, cnt2, dbl_fault, stuck, irq} !== 32'h0) begin
      miscompares++;
      $display("[TB] FAIL reset_state: got %h expected 0", {mis, cnt0, cnt1, cnt2, dbl_fault, stuck, irq});
    end
    #3 rst_n = 1'b1;
  endtask

  task automatic test_clean();
    set_reps(8'hA5, 8'hA5, 8'hA5);
    for (int i = 0; i < 10; i++) begin
      tick();
      vectors++;
      if ({mis, cnt0, cnt1, cnt2, irq} !== 28'h0) begin
        miscompares++;
        $display("[TB] FAIL clean_cycle%0d: mis=%b cnt=%0d/%0d/%0d irq=%b expected all 0", i, mis, cnt0, cnt1, cnt2, irq);
      end
    end
  endtask

  task automatic test_single_upset();
    set_reps(8'hA5, 8'hA4, 8'hA5);
    tick();
    set_reps(8'hA5, 8'hA5, 8'hA5);
    vectors++;
    if (mis !== 3'b010) begin
      miscompares++;
      $display("[TB] FAIL single_mis: got %b expected 010", mis);
    end
    vectors++;
    if (cnt1 !== 8'd1 || cnt0 !== 8'd0 || cnt2 !== 8'd0) begin
      miscompares++;
      $display("[TB] FAIL single_cnt: got %0d/%0d/%0d expected 0/1/0", cnt0, cnt1, cnt2);
    end
    vectors++;
    if (dbl_fault !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL single_dbl: got %b expected 0", dbl_fault);
    end
    tick();
    vectors++;
    if (mis !== 3'b000 || cnt1 !== 8'd1) begin
      miscompares++;
      $display("[TB] FAIL single_hold: mis=%b cnt1=%0d expected 000/1", mis, cnt1);
    end
  endtask

  task automatic test_double_fault();
    // vote = 8'h00, so r0 and r2 each disagree in one bit
    set_reps(8'h01, 8'h00, 8'h80);
    tick();
    set_reps(8'hA5, 8'hA5, 8'hA5);
    vectors++;
    if (mis !== 3'b101 || dbl_fault !== 1'b1 || irq !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL dbl_set: mis=%b dbl=%b irq=%b expected 101/1/0", mis, dbl_fault, irq);
    end
    vectors++;
    if (cnt0 !== 8'd1 || cnt1 !== 8'd1 || cnt2 !== 8'd1) begin
      miscompares++;
      $display("[TB] FAIL dbl_cnt: got %0d/%0d/%0d expected 1/1/1", cnt0, cnt1, cnt2);
    end
    tick();
    vectors++;
    if (irq !== 1'b1 || dbl_fault !== 1'b1 || mis !== 3'b000) begin
      miscompares++;
      $display("[TB] FAIL dbl_irq: irq=%b dbl=%b mis=%b expected 1/1/000", irq, dbl_fault, mis);
    end
    clr = 1'b1;
    tick();
    clr = 1'b0;
    vectors++;
    if (dbl_fault !== 1'b0 || irq !== 1'b1 || {cnt0, cnt1, cnt2} !== 24'h0) begin
      miscompares++;
      $display("[TB] FAIL dbl_clr: dbl=%b irq=%b cnt=%0d/%0d/%0d expected 0/1/0/0/0", dbl_fault, irq, cnt0, cnt1, cnt2);
    end
    tick();
    vectors++;
    if (irq !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL dbl_irq_clr: got %b expected 0", irq);
    end
  endtask

  task automatic test_stuck();
    set_reps(8'hA5, 8'hA5, 8'h25);
    for (int k = 1; k <= 4; k++) begin
      tick();
      vectors++;
      if (mis !== 3'b100 || cnt2 !== 8'(k) || stuck !== 3'b000) begin
        miscompares++;
        $display("[TB] FAIL stuck_run%0d: mis=%b cnt2=%0d stuck=%b expected 100/%0d/000", k, mis, cnt2, stuck, k);
      end
    end
    set_reps(8'hA5, 8'hA5, 8'hA5);
    tick();
    vectors++;
    if (stuck !== {STK, 2'b00} || irq !== 1'b0 || mis !== 3'b000) begin
      miscompares++;
      $display("[TB] FAIL stuck_set: stuck=%b irq=%b mis=%b expected %b/0/000", stuck, irq, mis, {STK, 2'b00});
    end
    tick();
    vectors++;
    if (irq !== STK || stuck !== {STK, 2'b00}) begin
      miscompares++;
      $display("[TB] FAIL stuck_irq: irq=%b stuck=%b expected %b/%b", irq, stuck, STK, {STK, 2'b00});
    end
    clean_up();
    vectors++;
    if (stuck !== 3'b000 || irq !== 1'b0 || cnt2 !== 8'd0) begin
      miscompares++;
      $display("[TB] FAIL stuck_clr: stuck=%b irq=%b cnt2=%0d expected 000/0/0", stuck, irq, cnt2);
    end
  endtask

  task automatic test_saturate();
    set_reps(8'hFF, 8'h00, 8'h00);
    for (int k = 1; k <= 300; k++) begin
      tick();
      if (k == 254 || k == 255 || k == 300) begin
        vectors++;
        if (cnt0 !== ((k == 254) ? 8'd254 : 8'd255)) begin
          miscompares++;
          $display("[TB] FAIL sat_cycle%0d: cnt0=%0d expected %0d", k, cnt0, (k == 254) ? 254 : 255);
        end
      end
    end
    vectors++;
    if (stuck !== {2'b00, STK} || dbl_fault !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL sat_flags: stuck=%b dbl=%b expected %b/0", stuck, dbl_fault, {2'b00, STK});
    end
    clean_up();
  endtask

  task automatic test_back_to_back_clr();
    // clr coincident with an r0 mismatch reloads 1
    set_reps(8'hA4, 8'hA5, 8'hA5);
    tick();
    tick();
    clr = 1'b1;
    tick();
    vectors++;
    if (cnt0 !== 8'd1) begin
      miscompares++;
      $display("[TB] FAIL clr_with_mis: cnt0=%0d expected 1", cnt0);
    end
    // clr coincident with a double fault: set wins over clear
    set_reps(8'h01, 8'h00, 8'h80);
    tick();
    clr = 1'b0;
    vectors++;
    if (dbl_fault !== 1'b1 || cnt0 !== 8'd1 || cnt2 !== 8'd1) begin
      miscompares++;
      $display("[TB] FAIL clr_with_dbl: dbl=%b cnt0=%0d cnt2=%0d expected 1/1/1", dbl_fault, cnt0, cnt2);
    end
    clean_up();
  endtask

  task automatic test_reset_mid();
    set_reps(8'hA4, 8'hA5, 8'hA5);
    tick();
    tick();
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if ({mis, cnt0, cnt1, cnt2, dbl_fault, stuck, irq} !== 32'h0) begin
      miscompares++;
      $display("[TB] FAIL reset_async: got %h expected 0", {mis, cnt0, cnt1, cnt2, dbl_fault, stuck, irq});
    end
    #2 rst_n = 1'b1;
    tick();
    vectors++;
    if (cnt0 !== 8'd1 || mis !== 3'b001) begin
      miscompares++;
      $display("[TB] FAIL reset_restart: cnt0=%0d mis=%b expected 1/001", cnt0, mis);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    test_reset();
    test_clean();
    test_single_upset();
    test_double_fault();
    test_stuck();
    test_saturate();
    test_back_to_back_clr();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached before completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
